// File: rtl/user_gpio_wb_pkg.sv
// user_gpio_wb_pkg: register offsets, ack FSM states and byte-lane helper for the user GPIO block
package user_gpio_wb_pkg;
  typedef enum logic {IDLE, ACK} state_t;
  localparam logic [2:0] R_DATA = 3'd0;
  localparam logic [2:0] R_OE = 3'd1;
  localparam logic [2:0] R_IN = 3'd2;
  localparam logic [2:0] R_SET = 3'd3;
  localparam logic [2:0] R_CLR = 3'd4;
  localparam logic [2:0] R_TOG = 3'd5;
  localparam logic [2:0] R_EDGE = 3'd6;
  localparam logic [2:0] R_IRQEN = 3'd7;
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/user_gpio_wb_sync.sv
// user_gpio_wb_sync: 2-flop pad synchroniser with rising-edge detect on the synchronised value
module user_gpio_wb_sync #(
  parameter int W = 24
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic [W-1:0] io_in,
  output logic [W-1:0] s2,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, prev;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= io_in;
      s2 <= s1;
      prev <= s2;
    end
  assign rise = s2 & ~prev;
endmodule

// File: rtl/user_gpio_wb.sv
// user_gpio_wb: Wishbone GPIO slave with set/clear/toggle, synchronised inputs, sticky edges and irq
module user_gpio_wb
  import user_gpio_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NGPIO     = 24
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NGPIO-1:0] io_in,
  output logic [NGPIO-1:0] io_out,
  output logic [NGPIO-1:0] io_oeb,
  output logic             irq_o
);
  state_t state, state_nx;
  logic req, wr, in_regs, irq_q, unused_adr;
  logic [2:0] idx;
  logic [NGPIO-1:0] out_q, oe_q, edge_q, irq_en_q, din, rise, m, d, clr, out_nx, rd;
  logic [31:0] dat_q;
  assign unused_adr = ^wbs_adr_i[1:0];
  assign idx = wbs_adr_i[4:2];
  assign in_regs = wbs_adr_i[7:5] == 3'd0;
  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & (state == IDLE);
  assign wr = req & wbs_we_i & in_regs;
  assign m = NGPIO'(lane_mask(wbs_sel_i));
  assign d = NGPIO'(wbs_dat_i) & m;
  assign clr = (wr && idx == R_EDGE) ? d : '0;
  user_gpio_wb_sync #(.W(NGPIO)) u_sync (
    .clock (clock),
    .resetb(resetb),
    .io_in (io_in),
    .s2    (din),
    .rise  (rise)
  );
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = req ? ACK : IDLE;
  always_comb wbs_ack_o = state == ACK;
  always_comb begin
    out_nx = out_q;
    if (wr)
      out_nx = idx == R_DATA ? (out_q & ~m) | d :
               idx == R_SET  ? out_q | d :
               idx == R_CLR  ? out_q & ~d :
               idx == R_TOG  ? out_q ^ d : out_q;
  end
  always_comb
    rd = !in_regs         ? '0 :
         idx == R_DATA    ? out_q :
         idx == R_OE      ? oe_q :
         idx == R_IN      ? din :
         idx == R_EDGE    ? edge_q :
         idx == R_IRQEN   ? irq_en_q : '0;
  // Register updates land on the same edge that raises ack, so pads move in the ack cycle.
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      out_q <= '0;
      oe_q <= '0;
      edge_q <= '0;
      irq_en_q <= '0;
      irq_q <= 1'b0;
      dat_q <= '0;
    end else begin
      out_q <= out_nx;
      if (wr && idx == R_OE) oe_q <= (oe_q & ~m) | d;
      if (wr && idx == R_IRQEN) irq_en_q <= (irq_en_q & ~m) | d;
      edge_q <= (edge_q & ~clr) | rise;
      irq_q <= |(edge_q & irq_en_q);
      dat_q <= (req && !wbs_we_i) ? 32'(rd) : '0;
    end
  assign wbs_dat_o = dat_q;
  assign io_out = out_q;
  assign io_oeb = ~oe_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_user_gpio_wb.sv
// tb_user_gpio_wb: randomized self-checking bench for user_gpio_wb against a bitwise register model
module tb_user_gpio_wb;
  localparam int N = 24;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clock = 0, resetb = 0, cyc = 0, stb = 0, we = 0, ack, irq;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic [N-1:0] io_in = 0, io_out, io_oeb;
  logic [N-1:0] m_out = 0, m_oe = 0, m_edge = 0, m_irqen = 0;
  logic [N-1:0] pad_before, pad_at_ack, oeb_at_ack;
  int n_cmp = 0, n_bad = 0;

  user_gpio_wb #(.BASE_ADDR(BASE), .NGPIO(N)) dut (
    .clock(clock), .resetb(resetb), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq_o(irq)
  );

  always #5 clock = ~clock;

  function automatic void m_write(input logic [2:0] idx, input logic [31:0] dv, input logic [3:0] s);
    for (int b = 0; b < N; b++)
      if (s[b/8])
        case (idx)
          3'd0: m_out[b] = dv[b];
          3'd1: m_oe[b] = dv[b];
          3'd3: if (dv[b]) m_out[b] = 1'b1;
          3'd4: if (dv[b]) m_out[b] = 1'b0;
          3'd5: if (dv[b]) m_out[b] = ~m_out[b];
          3'd6: if (dv[b]) m_edge[b] = 1'b0;
          3'd7: m_irqen[b] = dv[b];
          default: ;
        endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    if (off >= 8'h20) return 32'h0;
    case (off[4:2])
      3'd0: return 32'(m_out);
      3'd1: return 32'(m_oe);
      3'd2: return 32'(io_in);
      3'd6: return 32'(m_edge);
      3'd7: return 32'(m_irqen);
      default: return 32'h0;
    endcase
  endfunction

  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] dv,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(negedge clock);
    pad_before = io_out;
    cyc = 1; stb = 1; we = w; adr = a; wdat = dv; sel = s; lat = -1; rd = '0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clock); #1;
      if (ack) begin
        lat = i; rd = rdat; pad_at_ack = io_out; oeb_at_ack = io_oeb;
        break;
      end
    end
    cyc = 0; stb = 0; we = 0;
    if (lat > 0) begin
      @(posedge clock); #1;
      n_cmp++;
      if (ack !== 1'b0 || rdat !== 32'h0) begin
        n_bad++; $display("FAIL ack_drop adr=%h: ack=%b dat=%h, want ack=0 dat=0", a, ack, rdat);
      end
    end
  endtask

  task automatic do_write(input logic [7:0] off, input logic [31:0] dv, input logic [3:0] s);
    logic [31:0] rd; int lat;
    wb_access(BASE + 32'(off), 1'b1, dv, s, rd, lat);
    if (off < 8'h20) m_write(off[4:2], dv, s);
    n_cmp++;
    if (lat !== 1 || pad_at_ack !== m_out || oeb_at_ack !== ~m_oe) begin
      n_bad++;
      $display("FAIL write off=%h: lat=%0d io_out=%h io_oeb=%h, want lat=1 io_out=%h io_oeb=%h",
               off, lat, pad_at_ack, oeb_at_ack, m_out, ~m_oe);
    end
  endtask

  task automatic do_read(input logic [7:0] off);
    logic [31:0] rd, exp; int lat;
    exp = m_read(off);
    wb_access(BASE + 32'(off), 1'b0, 32'h0, 4'hF, rd, lat);
    n_cmp++;
    if (lat !== 1 || rd !== exp) begin
      n_bad++; $display("FAIL read off=%h: lat=%0d data=%h, want lat=1 data=%h", off, lat, rd, exp);
    end
  endtask

  task automatic reset_model();
    m_out = 0; m_oe = 0; m_edge = 0; m_irqen = 0;
  endtask

  task automatic test_reset();
    resetb = 0; io_in = 0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (io_oeb !== {N{1'b1}} || io_out !== '0 || ack !== 1'b0 || irq !== 1'b0 || rdat !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: oeb=%h out=%h ack=%b irq=%b dat=%h, want oeb=ffffff out=0 ack=0 irq=0 dat=0",
               io_oeb, io_out, ack, irq, rdat);
    end
    @(negedge clock) resetb = 1;
    reset_model();
    for (int o = 0; o < 8; o++) do_read(8'(o * 4));
  endtask

  task automatic test_toggle();
    do_write(8'h04, 32'hFFFFFF, 4'hF);
    do_write(8'h00, 32'hFFFFFF, 4'hF);
    for (int i = 0; i < 8; i++) begin
      do_write(8'h10, 32'hFFFFFF, 4'hF);
      n_cmp++;
      if (pad_before !== {N{1'b1}} || pad_at_ack !== '0) begin
        n_bad++; $display("FAIL toggle_clr %0d: before=%h at_ack=%h, want ffffff then 0", i, pad_before, pad_at_ack);
      end
      do_write(8'h0C, 32'hFFFFFF, 4'hF);
      n_cmp++;
      if (pad_before !== '0 || pad_at_ack !== {N{1'b1}}) begin
        n_bad++; $display("FAIL toggle_set %0d: before=%h at_ack=%h, want 0 then ffffff", i, pad_before, pad_at_ack);
      end
    end
  endtask

  task automatic test_lanes();
    do_write(8'h00, 32'h0, 4'hF);
    do_write(8'h0C, 32'h0000F0, 4'b0001);
    do_write(8'h14, 32'h00FF00, 4'b0011);
    n_cmp++;
    if (m_out !== 24'h00FFF0) begin
      n_bad++; $display("FAIL lane_model: model=%h, want 00fff0", m_out);
    end
    do_read(8'h00);
    do_write(8'h14, 32'h00FFFF, 4'b0100);
    do_read(8'h00);
    do_write(8'h00, 32'hFFFFFFFF, 4'hF);
    do_read(8'h00);
  endtask

  task automatic test_edge_irq();
    do_write(8'h1C, 32'h20, 4'hF);
    @(posedge clock); #1;
    io_in[5] = 1'b1;
    m_edge[5] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (irq !== 1'b0 || dut.edge_q !== 24'h20) begin
      n_bad++; $display("FAIL edge_cycle3: irq=%b edge=%h, want irq=0 edge=000020", irq, dut.edge_q);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL irq_rise: irq=%b, want 1", irq);
    end
    do_read(8'h08);
    do_read(8'h18);
    do_write(8'h18, 32'h20, 4'hF);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL irq_clear: irq=%b, want 0", irq);
    end
    do_read(8'h18);
    io_in[5] = 1'b0;
    repeat (4) @(posedge clock);
    do_write(8'h18, 32'h20, 4'hF);
    @(posedge clock); #1;
    io_in[5] = 1'b1;
    repeat (2) @(posedge clock);
    do_write(8'h18, 32'h20, 4'hF);
    m_edge[5] = 1'b1;
    do_read(8'h18);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL irq_coincident: irq=%b, want 1", irq);
    end
  endtask

  task automatic test_decode();
    logic [31:0] rd; int lat, acks; logic prev_ack, dbl;
    do_write(8'h40, 32'hFFFFFFFF, 4'hF);
    do_read(8'h40);
    do_read(8'hE4);
    do_read(8'h00);
    wb_access(32'h3000_0100, 1'b1, 32'h0, 4'hF, rd, lat);
    n_cmp++;
    if (lat !== -1) begin
      n_bad++; $display("FAIL out_of_window: lat=%0d, want no ack", lat);
    end
    do_read(8'h00);
    @(negedge clock);
    cyc = 1; stb = 1; we = 0; adr = BASE; acks = 0; prev_ack = 0; dbl = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (ack) acks++;
      if (ack && prev_ack) dbl = 1;
      prev_ack = ack;
    end
    cyc = 0; stb = 0;
    @(posedge clock); #1;
    n_cmp++;
    if (acks !== 2 || dbl !== 1'b0) begin
      n_bad++; $display("FAIL stb_held: acks=%0d consecutive=%b, want 2 single-cycle acks", acks, dbl);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] nv;
    logic [7:0] off;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) begin
        nv = N'($urandom);
        m_edge = m_edge | (nv & ~io_in);
        io_in = nv;
        repeat (5) @(posedge clock);
      end
      off = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 63) * 4) : 8'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 1) == 1) do_write(off, $urandom, 4'($urandom));
      else do_read(off);
      n_cmp++;
      if (io_out !== m_out || io_oeb !== ~m_oe || irq !== |(m_edge & m_irqen)) begin
        n_bad++;
        $display("FAIL random %0d: out=%h oeb=%h irq=%b, want out=%h oeb=%h irq=%b",
                 i, io_out, io_oeb, irq, m_out, ~m_oe, |(m_edge & m_irqen));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(8'h04, 32'hA5A5A5, 4'hF);
    do_write(8'h00, 32'h5A5A5A, 4'hF);
    @(negedge clock);
    cyc = 1; stb = 1; we = 0; adr = BASE;
    @(posedge clock); #1;
    n_cmp++;
    if (ack !== 1'b1) begin
      n_bad++; $display("FAIL mid_ack: ack=%b, want 1", ack);
    end
    #2 resetb = 0;
    #1;
    n_cmp++;
    if (ack !== 1'b0 || rdat !== 32'h0 || io_oeb !== {N{1'b1}} || io_out !== '0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: ack=%b dat=%h oeb=%h out=%h irq=%b, want 0/0/ffffff/0/0",
               ack, rdat, io_oeb, io_out, irq);
    end
    cyc = 0; stb = 0; io_in = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) resetb = 1;
    reset_model();
    for (int o = 0; o < 8; o++) do_read(8'(o * 4));
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_lanes();
    test_edge_irq();
    test_decode();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end
endmodule
